bus_cmd_master: RTL

BUS_CMD_MASTER -- requirements
Module: bus_cmd_master

---
 rtl/bus_cmd_pkg.sv | 18 +
 rtl/bus_cmd_timer.sv | 19 +
 rtl/bus_cmd_master.sv | 107 ++++++++++
 3 files changed

// File: rtl/bus_cmd_pkg.sv
// bus_cmd_pkg: shared states, command/response bytes and address check for bus_cmd_master
package bus_cmd_pkg;
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_DATA = 3'd2,
    S_EXEC = 3'd3,
    S_RESP = 3'd4,
    S_SENT = 3'd5
  } state_t;
  localparam logic [7:0] OP_RD   = 8'h52;
  localparam logic [7:0] OP_WR   = 8'h57;
  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h45;
  function automatic logic addr_ok(input logic [31:0] a, input logic [31:0] lo, input logic [31:0] hi);
    return (a[1:0] == 2'b00) && (a >= lo) && (a <= hi);
  endfunction
endpackage

// File: rtl/bus_cmd_timer.sv
// bus_cmd_timer: saturating inter-byte idle counter, expired on the LIMIT-th idle cycle
module bus_cmd_timer #(
  parameter int unsigned LIMIT = 1000000
) (
  input  logic sysclk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [W-1:0] MAX = W'(LIMIT - 1);
  logic [W-1:0] cnt;
  always_ff @(posedge sysclk or posedge reset)
    if (reset) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (enable && cnt != MAX) cnt <= cnt + 1'b1;
  assign expired = enable && !clear && cnt == MAX;
endmodule

// File: rtl/bus_cmd_master.sv
// bus_cmd_master: byte-stream command decoder driving a 32-bit read/write bus and returning response bytes
module bus_cmd_master
  import bus_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter logic [31:0] ADDR_LO = 32'h40000000,
  parameter logic [31:0] ADDR_HI = 32'h40000020
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        tx_ready,
  output logic        tx_en,
  output logic [7:0]  tx_data,
  output logic        rd,
  output logic        wr,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic        busy,
  output logic        err
);
  state_t      state;
  logic        is_wr;
  logic        seen_low;
  logic [1:0]  byte_cnt;
  logic [2:0]  resp_cnt;
  logic [31:0] resp_sr;
  logic        collecting;
  logic        expired;
  logic        legal;
  logic        bad_op;
  logic        drop;
  assign collecting = state == S_ADDR || state == S_DATA;
  assign legal      = addr_ok(addr, ADDR_LO, ADDR_HI);
  assign bad_op     = rx_data != OP_RD && rx_data != OP_WR;
  assign drop       = rx_valid && (state == S_EXEC || state == S_RESP || state == S_SENT);
  assign rd         = state == S_EXEC && legal && !is_wr;
  assign wr         = state == S_EXEC && legal && is_wr;
  assign tx_en      = state == S_RESP && tx_ready;
  assign tx_data    = resp_sr[31:24];
  assign busy       = state != S_IDLE;
  assign err        = (rx_valid && state == S_IDLE && bad_op) || drop || (state == S_EXEC && !legal) || expired;
  bus_cmd_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
    .sysclk (sysclk),
    .reset  (reset),
    .clear  (rx_valid || !collecting),
    .enable (collecting),
    .expired(expired)
  );
  always_ff @(posedge sysclk or posedge reset)
    if (reset) begin
      state    <= S_IDLE;
      is_wr    <= 1'b0;
      seen_low <= 1'b0;
      byte_cnt <= '0;
      resp_cnt <= '0;
      resp_sr  <= '0;
      addr     <= '0;
      wdata    <= '0;
    end else begin
      case (state)
        S_IDLE:
          if (rx_valid) begin
            byte_cnt <= '0;
            is_wr    <= rx_data == OP_WR;
            resp_sr  <= bad_op ? {RSP_ERR, 24'h0} : resp_sr;
            resp_cnt <= bad_op ? 3'd1 : resp_cnt;
            state    <= bad_op ? S_RESP : S_ADDR;
          end
        S_ADDR:
          if (expired) state <= S_IDLE;
          else if (rx_valid) begin
            addr     <= {addr[23:0], rx_data};
            byte_cnt <= byte_cnt + 1'b1;
            if (byte_cnt == 2'd3) state <= is_wr ? S_DATA : S_EXEC;
          end
        S_DATA:
          if (expired) state <= S_IDLE;
          else if (rx_valid) begin
            wdata    <= {wdata[23:0], rx_data};
            byte_cnt <= byte_cnt + 1'b1;
            if (byte_cnt == 2'd3) state <= S_EXEC;
          end
        S_EXEC: begin
          // rdata is only valid while rd is high, so the read result is captured here
          resp_sr  <= !legal ? {RSP_ERR, 24'h0} : is_wr ? {RSP_OK, 24'h0} : rdata;
          resp_cnt <= (legal && !is_wr) ? 3'd4 : 3'd1;
          state    <= S_RESP;
        end
        S_RESP:
          if (tx_ready) begin
            seen_low <= 1'b0;
            state    <= S_SENT;
          end
        S_SENT:
          if (!tx_ready) seen_low <= 1'b1;
          else if (seen_low) begin
            resp_cnt <= resp_cnt - 1'b1;
            resp_sr  <= (resp_cnt > 3'd1) ? {resp_sr[23:0], 8'h00} : resp_sr;
            state    <= (resp_cnt > 3'd1) ? S_RESP : S_IDLE;
          end
        default: state <= S_IDLE;
      endcase
    end
endmodule
